// File: rtl/regf_pkg.sv
// Shared definitions for the descriptor register bank and its fetch engine.
package regf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } desc_state_e;

  localparam int unsigned DESC_BYTES_DEF = 8;
  localparam int unsigned DUMMY_BASE_DEF = 450;
  localparam logic [63:0] DUMMY_DESC_DEF = 64'h0000_0000_1800_8F81;

  // Byte offsets of descriptor fields as seen by the HDR engine and CCC counters.
  localparam int unsigned DESC_OFS_CMD   = 0;
  localparam int unsigned DESC_OFS_ATTR  = 1;
  localparam int unsigned DESC_OFS_ADDR  = 2;
  localparam int unsigned DESC_OFS_CCC   = 3;
  localparam int unsigned DESC_OFS_LEN   = 4;

endpackage

// File: rtl/regf_desc_fetch.sv
// Descriptor fetch engine: streams DESC_BYTES bytes out of the array and holds
// the assembled word under a valid/ack handshake.
module regf_desc_fetch
  import regf_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned ADDR       = 12,
  parameter int unsigned DESC_BYTES = DESC_BYTES_DEF
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_req,
  input  logic [ADDR-1:0]               i_base,
  input  logic                          i_ack,
  input  logic                          i_grant,
  output logic [ADDR-1:0]               o_rd_addr,
  input  logic [WIDTH-1:0]              i_rd_data,
  output logic                          o_busy,
  output logic                          o_valid,
  output logic [WIDTH*DESC_BYTES-1:0]   o_data
);

  localparam int unsigned     IDXW = (DESC_BYTES > 1) ? $clog2(DESC_BYTES) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(DESC_BYTES - 1);

  desc_state_e                 r_state;
  desc_state_e                 w_state_nxt;
  logic [ADDR-1:0]             r_base;
  logic [IDXW-1:0]             r_idx;
  logic [WIDTH*DESC_BYTES-1:0] r_data;
  logic                        w_cap;

  assign w_cap     = (r_state == ST_FETCH) && i_grant;
  assign o_rd_addr = r_base + ADDR'(r_idx);
  assign o_data    = r_data;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (i_req) w_state_nxt = ST_FETCH;
      ST_FETCH: if (w_cap && (r_idx == LAST)) w_state_nxt = ST_HOLD;
      ST_HOLD:  if (i_ack) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    o_busy  = (r_state != ST_IDLE);
    o_valid = (r_state == ST_HOLD);
  end

  // Assembly register is not cleared on a new fetch: old bytes stay visible until overwritten.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_base <= '0;
      r_idx  <= '0;
      r_data <= '0;
    end else if ((r_state == ST_IDLE) && i_req) begin
      r_base <= i_base;
      r_idx  <= '0;
    end else if (w_cap) begin
      r_data[WIDTH*r_idx +: WIDTH] <= i_rd_data;
      r_idx                        <= r_idx + IDXW'(1);
    end
  end

endmodule

// File: rtl/regf_desc_bank.sv
// Byte-addressed register file with host port, write-protected dummy descriptor
// region and an attached descriptor fetch engine.
module regf_desc_bank
  import regf_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned ADDR       = 12,
  parameter int unsigned DEPTH      = 2**ADDR,
  parameter int unsigned DESC_BYTES = DESC_BYTES_DEF,
  parameter int unsigned DUMMY_BASE = DUMMY_BASE_DEF,
  parameter logic [WIDTH*DESC_BYTES-1:0] DUMMY_DESC = DUMMY_DESC_DEF
) (
  input  logic                        i_regf_clk,
  input  logic                        i_regf_rst_n,
  input  logic                        i_regf_rd_en,
  input  logic                        i_regf_wr_en,
  input  logic [ADDR-1:0]             i_regf_addr,
  input  logic [WIDTH-1:0]            i_regf_data_wr,
  output logic [WIDTH-1:0]            o_regf_data_rd,
  output logic                        o_regf_rd_valid,
  output logic                        o_regf_wr_err,
  input  logic                        i_desc_req,
  input  logic [ADDR-1:0]             i_desc_base,
  input  logic                        i_desc_ack,
  output logic                        o_desc_busy,
  output logic                        o_desc_valid,
  output logic [WIDTH*DESC_BYTES-1:0] o_desc_data
);

  localparam logic [ADDR:0] PROT_LO = (ADDR+1)'(DUMMY_BASE);
  localparam logic [ADDR:0] PROT_HI = (ADDR+1)'(DUMMY_BASE + DESC_BYTES);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_data_rd;
  logic             r_rd_valid;
  logic             r_wr_err;
  logic             w_prot;
  logic [ADDR-1:0]  w_fetch_addr;
  logic [WIDTH-1:0] w_fetch_data;

  assign w_prot = ({1'b0, i_regf_addr} >= PROT_LO) && ({1'b0, i_regf_addr} < PROT_HI);
  // Fetch reads the pre-edge array contents, so a same-edge host write captures the old byte.
  assign w_fetch_data = r_mem[w_fetch_addr];

  always_ff @(posedge i_regf_clk or negedge i_regf_rst_n) begin
    if (!i_regf_rst_n) begin
      for (int unsigned k = 0; k < DEPTH; k++) r_mem[ADDR'(k)] <= '0;
      for (int unsigned d = 0; d < DESC_BYTES; d++)
        r_mem[ADDR'(DUMMY_BASE + d)] <= DUMMY_DESC[WIDTH*d +: WIDTH];
    end else if (i_regf_wr_en && !w_prot) begin
      r_mem[i_regf_addr] <= i_regf_data_wr;
    end
  end

  always_ff @(posedge i_regf_clk or negedge i_regf_rst_n) begin
    if (!i_regf_rst_n) begin
      r_data_rd  <= '0;
      r_rd_valid <= 1'b0;
      r_wr_err   <= 1'b0;
    end else begin
      if (i_regf_rd_en) r_data_rd <= r_mem[i_regf_addr];
      r_rd_valid <= i_regf_rd_en;
      r_wr_err   <= i_regf_wr_en && w_prot;
    end
  end

  assign o_regf_data_rd  = r_data_rd;
  assign o_regf_rd_valid = r_rd_valid;
  assign o_regf_wr_err   = r_wr_err;

  regf_desc_fetch #(
    .WIDTH      (WIDTH),
    .ADDR       (ADDR),
    .DESC_BYTES (DESC_BYTES)
  ) u_fetch (
    .i_clk     (i_regf_clk),
    .i_rst_n   (i_regf_rst_n),
    .i_req     (i_desc_req),
    .i_base    (i_desc_base),
    .i_ack     (i_desc_ack),
    .i_grant   (!i_regf_rd_en),
    .o_rd_addr (w_fetch_addr),
    .i_rd_data (w_fetch_data),
    .o_busy    (o_desc_busy),
    .o_valid   (o_desc_valid),
    .o_data    (o_desc_data)
  );

endmodule

// File: tb/tb_regf_desc_bank.sv
// Bench for regf_desc_bank: directed scenarios plus randomized traffic against a reference model.
module tb_regf_desc_bank;

  localparam int unsigned DB    = 8;
  localparam logic [63:0] DUMMY = 64'h0000_0000_1800_8F81;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd_en = 1'b0, wr_en = 1'b0, req = 1'b0, ack = 1'b0;
  logic [11:0] addr = '0, base = '0;
  logic [7:0]  wdata = '0;
  logic [7:0]  data_rd;
  logic        rd_valid, wr_err, busy, valid;
  logic [63:0] desc;

  always #5 clk = ~clk;

  regf_desc_bank #(
    .WIDTH(8), .ADDR(12), .DEPTH(4096), .DESC_BYTES(8),
    .DUMMY_BASE(450), .DUMMY_DESC(64'h0000_0000_1800_8F81)
  ) dut (
    .i_regf_clk(clk), .i_regf_rst_n(rst_n),
    .i_regf_rd_en(rd_en), .i_regf_wr_en(wr_en),
    .i_regf_addr(addr), .i_regf_data_wr(wdata),
    .o_regf_data_rd(data_rd), .o_regf_rd_valid(rd_valid), .o_regf_wr_err(wr_err),
    .i_desc_req(req), .i_desc_base(base), .i_desc_ack(ack),
    .o_desc_busy(busy), .o_desc_valid(valid), .o_desc_data(desc)
  );

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model: array contents, descriptor byte snapshots, handshake phase.
  logic [7:0]  m_mem [4096];
  logic [7:0]  m_desc [DB];
  logic [7:0]  m_rd;
  logic [11:0] m_base;
  bit          m_rdv, m_werr, m_fetch, m_hold;
  int          m_k;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: observed %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] m_word();
    logic [63:0] w;
    for (int i = 0; i < DB; i++) w[8*i +: 8] = m_desc[i];
    return w;
  endfunction

  task automatic model_reset();
    logic [63:0] d;
    d = DUMMY;
    for (int i = 0; i < 4096; i++) m_mem[i] = 8'h00;
    for (int i = 0; i < DB; i++) m_mem[450 + i] = d[8*i +: 8];
    for (int i = 0; i < DB; i++) m_desc[i] = 8'h00;
    m_rd = 8'h00; m_rdv = 0; m_werr = 0; m_fetch = 0; m_hold = 0; m_k = 0; m_base = '0;
  endtask

  // Applies one clock edge's worth of inputs; captures use the array as it was before the edge.
  task automatic model_edge();
    if (m_fetch) begin
      if (!rd_en) begin
        m_desc[m_k] = m_mem[12'(m_base + 12'(m_k))];
        m_k++;
        if (m_k == DB) begin m_fetch = 0; m_hold = 1; end
      end
    end else if (m_hold) begin
      if (ack) m_hold = 0;
    end else if (req) begin
      m_fetch = 1; m_base = base; m_k = 0;
    end
    m_rdv = rd_en;
    if (rd_en) m_rd = m_mem[addr];
    m_werr = wr_en && (addr >= 12'd450) && (addr < 12'(450 + DB));
    if (wr_en && !m_werr) m_mem[addr] = wdata;
  endtask

  task automatic check_outputs();
    check_eq("rd_valid",  rd_valid, m_rdv);
    check_eq("wr_err",    wr_err,   m_werr);
    check_eq("data_rd",   data_rd,  m_rd);
    check_eq("busy",      busy,     m_fetch || m_hold);
    check_eq("valid",     valid,    m_hold);
    check_eq("desc_data", desc,     m_word());
  endtask

  task automatic cyc(input bit r, input bit w, input logic [11:0] a, input logic [7:0] d,
                     input bit q, input logic [11:0] b, input bit k);
    rd_en = r; wr_en = w; addr = a; wdata = d; req = q; base = b; ack = k;
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
    rd_en = 0; wr_en = 0; req = 0; ack = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0, '0, '0, 0, '0, 0);
  endtask

  task automatic wr(input logic [11:0] a, input logic [7:0] d);
    cyc(0, 1, a, d, 0, '0, 0);
  endtask

  task automatic hard_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("rst_valid", valid, 1'b0);
    check_eq("rst_busy",  busy,  1'b0);
    check_eq("rst_desc",  desc,  64'h0);
    check_outputs();
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  function automatic logic [11:0] rand_addr();
    case ($urandom_range(2))
      0:       return 12'h100 + 12'($urandom_range(15));
      1:       return 12'(440 + $urandom_range(24));
      default: return 12'hFFA + 12'($urandom_range(11));
    endcase
  endfunction

  initial begin
    hard_reset();

    // Dummy descriptor straight out of reset
    cyc(0, 0, '0, '0, 1, 12'd450, 0);
    idle(7);
    check_eq("dummy_early_valid", valid, 1'b0);
    idle(1);
    check_eq("dummy_valid", valid, 1'b1);
    check_eq("dummy_data",  desc,  64'h0000_0000_1800_8F81);
    idle(3);
    check_eq("dummy_busy_hold", busy, 1'b1);
    cyc(0, 0, '0, '0, 0, '0, 1);
    check_eq("dummy_ack_busy", busy, 1'b0);

    // Host write/readback and protected region
    wr(12'h010, 8'hA5);
    cyc(1, 0, 12'h010, '0, 0, '0, 0);
    check_eq("rb_data",  data_rd,  8'hA5);
    check_eq("rb_valid", rd_valid, 1'b1);
    idle(1);
    check_eq("rb_pulse", rd_valid, 1'b0);
    wr(12'd452, 8'h33);
    check_eq("prot_err", wr_err, 1'b1);
    cyc(1, 0, 12'd452, '0, 0, '0, 0);
    check_eq("prot_data", data_rd, 8'h00);
    check_eq("prot_err_pulse", wr_err, 1'b0);

    // Fetch stalled by three host reads
    for (int i = 0; i < 8; i++) wr(12'h100 + 12'(i), 8'(8'h11 * (i + 1)));
    cyc(0, 0, '0, '0, 1, 12'h100, 0);
    for (int i = 0; i < 10; i++) cyc((i == 1) || (i == 3) || (i == 5), 0, 12'h010, '0, 0, '0, 0);
    check_eq("stall_early_valid", valid, 1'b0);
    idle(1);
    check_eq("stall_valid", valid, 1'b1);
    check_eq("stall_data",  desc,  64'h8877_6655_4433_2211);
    cyc(0, 0, '0, '0, 0, '0, 1);

    // Address wrap
    wr(12'hFFE, 8'h01);
    wr(12'hFFF, 8'h02);
    for (int i = 0; i < 6; i++) wr(12'(i), 8'(i + 3));
    cyc(0, 0, '0, '0, 1, 12'hFFE, 0);
    idle(8);
    check_eq("wrap_data", desc, 64'h0807_0605_0403_0201);
    cyc(0, 0, '0, '0, 0, '0, 1);

    // Handshake corner cases
    cyc(0, 0, '0, '0, 1, 12'h100, 0);
    idle(8);
    cyc(0, 0, '0, '0, 1, 12'h000, 0);
    check_eq("hold_req_valid", valid, 1'b1);
    check_eq("hold_req_data",  desc,  64'h8877_6655_4433_2211);
    cyc(0, 0, '0, '0, 1, 12'h000, 1);
    check_eq("ackreq_busy", busy, 1'b0);
    cyc(0, 0, '0, '0, 1, 12'h100, 0);
    check_eq("req_after_ack_busy", busy, 1'b1);
    idle(8);
    cyc(0, 0, '0, '0, 0, '0, 1);

    // Reset in the middle of a fetch
    cyc(0, 0, '0, '0, 1, 12'h100, 0);
    idle(4);
    hard_reset();
    cyc(0, 0, '0, '0, 1, 12'h100, 0);
    idle(8);
    check_eq("post_rst_valid", valid, 1'b1);
    check_eq("post_rst_data",  desc,  64'h0);
    cyc(0, 0, '0, '0, 0, '0, 1);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      cyc($urandom_range(3) == 0, $urandom_range(9) < 3, rand_addr(), 8'($urandom),
          $urandom_range(3) == 0, rand_addr(), $urandom_range(9) < 3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
